// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-side packet framer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } framer_state_e;

  typedef enum logic [1:0] {
    ERR_CHECKSUM = 2'd0,
    ERR_LENGTH   = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_LINE     = 2'd3
  } framer_err_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, synchronous write, combinational read.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int PTR_W   = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_framer.sv
// Frames the uart byte stream: SYNC, LEN, payload, CHK; buffers good payloads and
// releases them on a valid/ready stream, reporting dropped frames with a cause code.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 104160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       recv_error,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int             PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  framer_state_e    r_state;
  framer_err_e      r_err_code;
  logic [7:0]       r_len;
  logic [7:0]       r_acc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_out_valid;
  logic [7:0]       r_out_byte;
  logic             r_out_last;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic             r_busy;

  logic             w_we;
  logic [7:0]       w_sum;
  logic [7:0]       w_wr_cnt;
  logic [7:0]       w_rd_next;
  logic [PTR_W-1:0] w_raddr;
  logic [7:0]       w_rdata;
  logic             w_timeout;

  assign w_we      = (r_state == ST_PAYLOAD) && received && !recv_error;
  assign w_sum     = r_acc + rx_byte;
  assign w_wr_cnt  = 8'(r_wr_ptr);
  assign w_rd_next = 8'(r_rd_ptr) + 8'd1;
  // Read address looks one entry ahead while draining so out_byte can be reloaded on a handshake.
  assign w_raddr   = (r_state == ST_DRAIN) ? w_rd_next[PTR_W-1:0] : '0;
  assign w_timeout = (r_to_cnt == TO_LAST);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .PTR_W   (PTR_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_byte),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_err_code  <= ERR_CHECKSUM;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_to_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'd0;
      r_out_last  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (received && rx_byte == SYNC_BYTE) begin
            r_state  <= ST_LEN;
            r_busy   <= 1'b1;
            r_acc    <= 8'd0;
            r_wr_ptr <= '0;
            r_to_cnt <= '0;
          end
        end
        ST_LEN, ST_PAYLOAD, ST_CHECK: begin
          // Line error outranks a byte in the same cycle; a byte outranks timeout expiry.
          if (recv_error) begin
            r_state     <= ST_HUNT;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_LINE;
          end else if (received) begin
            r_to_cnt <= '0;
            case (r_state)
              ST_LEN: begin
                if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                  r_state     <= ST_HUNT;
                  r_busy      <= 1'b0;
                  r_frame_err <= 1'b1;
                  r_err_code  <= ERR_LENGTH;
                end else begin
                  r_len   <= rx_byte;
                  r_acc   <= rx_byte;
                  r_state <= ST_PAYLOAD;
                end
              end
              ST_PAYLOAD: begin
                r_acc    <= w_sum;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_wr_cnt == r_len - 8'd1) r_state <= ST_CHECK;
              end
              default: begin
                if (w_sum == 8'd0) begin
                  r_state     <= ST_DRAIN;
                  r_frame_ok  <= 1'b1;
                  r_rd_ptr    <= '0;
                  r_out_valid <= 1'b1;
                  r_out_byte  <= w_rdata;
                  r_out_last  <= (r_len == 8'd1);
                end else begin
                  r_state     <= ST_HUNT;
                  r_busy      <= 1'b0;
                  r_frame_err <= 1'b1;
                  r_err_code  <= ERR_CHECKSUM;
                end
              end
            endcase
          end else if (w_timeout) begin
            r_state     <= ST_HUNT;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Bytes arriving while the buffer is still draining are dropped as overrun.
          if (received) begin
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_LINE;
          end
          if (r_out_valid && out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ST_HUNT;
              r_busy      <= 1'b0;
            end else begin
              r_rd_ptr   <= w_rd_next[PTR_W-1:0];
              r_out_byte <= w_rdata;
              r_out_last <= (w_rd_next == r_len - 8'd1);
            end
          end
        end
        default: begin
          r_state <= ST_HUNT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: a frame-level model predicts events and payload bytes.
module tb_uart_rx_framer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXL = 16;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       recv_error = 1'b0;
  logic       out_ready;
  logic       out_valid, out_last, frame_ok, frame_err, busy;
  logic [7:0] out_byte;
  logic [1:0] err_code;

  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b1;
  logic rdy_bit   = 1'b1;
  assign out_ready = rdy_rand ? rdy_bit : rdy_force;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_bytes [$];   // {last, byte}
  int         exp_ev    [$];   // 0..3 = err_code, 4 = frame_ok

  uart_rx_framer #(
    .SYNC_BYTE      (SYNC),
    .MAX_LEN        (MAXL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .received   (received),
    .rx_byte    (rx_byte),
    .recv_error (recv_error),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rdy_bit = ($urandom_range(0, 3) != 0);
  end

  // Frame-level reference: scan for SYNC, apply length and checksum rules to whole frames.
  task automatic predict(input logic [7:0] q[$]);
    int i = 0;
    while (i < q.size()) begin
      int len, sum;
      if (q[i] != SYNC) begin i++; continue; end
      if (i + 1 >= q.size()) break;
      len = int'(q[i+1]);
      if (len == 0 || len > MAXL) begin exp_ev.push_back(1); i += 2; continue; end
      if (i + 2 + len >= q.size()) break;
      sum = len;
      for (int k = 0; k < len; k++) sum += int'(q[i+2+k]);
      sum += int'(q[i+2+len]);
      if ((sum % 256) == 0) begin
        exp_ev.push_back(4);
        for (int k = 0; k < len; k++) exp_bytes.push_back({(k == len - 1), q[i+2+k]});
      end else begin
        exp_ev.push_back(0);
      end
      i += 3 + len;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    received = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    received = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$], input int maxgap);
    predict(q);
    foreach (q[k]) send_byte(q[k], $urandom_range(0, maxgap));
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || out_valid) && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy || out_valid) begin
      failures++;
      $display("FAIL %s_idle: busy=%0b out_valid=%0b, expected both 0 within 3000 clocks", tag, busy, out_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"},  int'(out_last),  0);
    check({tag, "_frame_ok"},  int'(frame_ok),  0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_err_code"},  int'(err_code),  0);
    check({tag, "_out_byte"},  int'(out_byte),  0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or an event.
  logic       prev_stall = 1'b0;
  logic [7:0] stall_byte = 8'd0;
  logic       stall_last = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_byte !== stall_byte || out_last !== stall_last) begin
          failures++;
          $display("FAIL stall_hold: valid=%0b byte=%02h last=%0b, expected valid=1 byte=%02h last=%0b",
                   out_valid, out_byte, out_last, stall_byte, stall_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          failures++;
          $display("FAIL out_stream: got byte=%02h last=%0b, expected no output", out_byte, out_last);
        end else begin
          logic [8:0] e;
          e = exp_bytes.pop_front();
          if ({out_last, out_byte} !== e) begin
            failures++;
            $display("FAIL out_stream: got byte=%02h last=%0b, expected byte=%02h last=%0b",
                     out_byte, out_last, e[7:0], e[8]);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      stall_byte = out_byte;
      stall_last = out_last;
      if (frame_ok || frame_err) begin
        int got;
        got = frame_ok ? 4 : int'(err_code);
        checks++;
        if (frame_ok && frame_err) begin
          failures++;
          $display("FAIL event: got frame_ok and frame_err together, expected one");
        end else if (exp_ev.size() == 0) begin
          failures++;
          $display("FAIL event: got %0d (4=ok), expected no event", got);
        end else begin
          int e;
          e = exp_ev.pop_front();
          if (got != e) begin
            failures++;
            $display("FAIL event: got %0d (4=ok), expected %0d", got, e);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    int k;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Good frame.
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_list(q, 0);
    wait_idle("good");
    check("good_busy_low", int'(busy), 0);

    // Bad checksum.
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_list(q, 1);
    repeat (2) @(posedge clk); #1;
    check("badchk_valid", int'(out_valid), 0);
    check("badchk_busy", int'(busy), 0);

    // Length errors with leading junk.
    q = '{8'h00, 8'hFF, 8'hA5, 8'h00};
    send_list(q, 1);
    q = '{8'hA5, 8'h11};
    send_list(q, 1);
    repeat (2) @(posedge clk); #1;
    check("lenerr_busy", int'(busy), 0);

    // Timeout: frame_err exactly TMO clocks after the edge that took the last byte.
    q = '{8'hA5, 8'h02, 8'h44};
    send_list(q, 0);
    exp_ev.push_back(2);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!frame_err && k < TMO + 20);
    check("timeout_latency", k, TMO);
    check("timeout_code", int'(err_code), 2);
    q = '{8'hA5, 8'h01, 8'h7E, 8'h81};
    send_list(q, 0);
    wait_idle("after_timeout");

    // Line error together with a byte: error wins.
    q = '{8'hA5, 8'h02};
    send_list(q, 0);
    exp_ev.push_back(3);
    @(posedge clk); #1;
    received = 1'b1; recv_error = 1'b1; rx_byte = 8'h55;
    @(posedge clk); #1;
    received = 1'b0; recv_error = 1'b0;
    check("lineerr_busy", int'(busy), 0);

    // Backpressure with an overrun strobe during the stall.
    rdy_force = 1'b0;
    q = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    send_list(q, 0);
    check("bp_valid", int'(out_valid), 1);
    exp_ev.push_back(3);
    send_byte(8'h5A, 0);
    repeat (2) @(posedge clk); #1;
    check("bp_byte_held", int'(out_byte), 8'h01);
    rdy_force = 1'b1;
    wait_idle("bp");

    // Reset mid-frame.
    q = '{8'hA5, 8'h03, 8'h11};
    foreach (q[j]) send_byte(q[j], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b0;
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    send_list(q, 0);
    wait_idle("after_rst");

    // Randomized frames with random backpressure.
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind, len, sum;
      logic [7:0] b;
      q = {};
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        q.push_back(b);
      end
      q.push_back(SYNC);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        q.push_back(8'h00);
      end else if (kind == 1) begin
        q.push_back(8'($urandom_range(MAXL + 1, 255)));
      end else begin
        len = $urandom_range(1, MAXL);
        q.push_back(8'(len));
        sum = len;
        for (int j = 0; j < len; j++) begin
          b = 8'($urandom_range(0, 255));
          q.push_back(b);
          sum += int'(b);
        end
        b = 8'((256 - (sum % 256)) % 256);
        if (kind == 2) b = b + 8'($urandom_range(1, 255));
        q.push_back(b);
      end
      send_list(q, 3);
      wait_idle("rand");
    end
    rdy_rand = 1'b0;

    repeat (5) @(posedge clk); #1;
    check("leftover_bytes", exp_bytes.size(), 0);
    check("leftover_events", exp_ev.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
